// File: rtl/ntt_poly_unloader.sv
// Streams the 4-bank NTT coefficient memory out in natural order, four 12-bit lanes per beat.
// Optional macro UNLOAD_MODQ_EN: lanes >= Q_MOD are reduced once on the FIFO-write path.
module ntt_poly_unloader #(
  parameter int RD_LAT     = 1,
  parameter int FIFO_DEPTH = 4,
  parameter int Q_MOD      = 3329
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        ren,
  output logic [6:0]  row,
  input  logic [11:0] q0,
  input  logic [11:0] q1,
  input  logic [11:0] q2,
  input  logic [11:0] q3,
  output logic [47:0] tdata,
  output logic        tvalid,
  input  logic        tready,
  output logic        tlast,
  output logic [1:0]  dbg_state
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int OW = $clog2(FIFO_DEPTH + RD_LAT + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [6:0]        next_row_q, next_row_d;
  logic [6:0]        last_row_q, last_row_d;
  logic [6:0]        beat_q, beat_d;
  logic [RD_LAT-1:0] vld_pipe_q;
  logic [1:0]        s_pipe_q [RD_LAT];
  logic [47:0]       fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     cnt_q;

  logic [OW-1:0]     inflight, outstanding;
  logic              issue, push, fire;
  logic [1:0]        s_issue;
  logic [11:0]       q_bank [4];
  logic [47:0]       wr_data;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(FIFO_DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  function automatic logic [11:0] reduce(input logic [11:0] x);
`ifdef UNLOAD_MODQ_EN
    return (x >= 12'(Q_MOD)) ? x - 12'(Q_MOD) : x;
`else
    return x;
`endif
  endfunction

  // Stream handshake: a beat moves on a rising edge where tvalid && tready; tvalid comes
  // only from FIFO occupancy, and tdata/tlast are the FIFO head, so both hold while stalled.
  assign fire   = tvalid && tready;
  assign push   = vld_pipe_q[RD_LAT-1];
  assign tvalid = (cnt_q != '0);
  assign tdata  = tvalid ? fifo_mem_q[rd_ptr_q] : '0;
  assign tlast  = tvalid && (beat_q == 7'd127);

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LAT; i++) inflight = inflight + OW'(vld_pipe_q[i]);
  end

  // Credit: every issued read already owns a FIFO slot, so the FIFO cannot overflow.
  assign outstanding = inflight + OW'(cnt_q);
  assign issue       = (state_q == S_RUN) && (outstanding < OW'(FIFO_DEPTH));
  assign s_issue     = 2'(next_row_q[6]) + next_row_q[5:4] + next_row_q[3:2] + next_row_q[1:0];

  assign busy      = (state_q == S_RUN) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign ren       = issue;
  assign row       = issue ? next_row_q : last_row_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d    = state_q;
    next_row_d = next_row_q;
    last_row_d = last_row_q;
    beat_d     = fire ? beat_q + 7'd1 : beat_q;
    case (state_q)
      S_IDLE: if (start) begin
        state_d    = S_RUN;
        next_row_d = '0;
        beat_d     = '0;
      end
      S_RUN: if (issue) begin
        last_row_d = next_row_q;
        next_row_d = next_row_q + 7'd1;
        if (next_row_q == 7'd127) state_d = S_DRAIN;
      end
      S_DRAIN: if (fire && (beat_q == 7'd127)) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      next_row_q <= '0;
      last_row_q <= '0;
      beat_q     <= '0;
    end else begin
      state_q    <= state_d;
      next_row_q <= next_row_d;
      last_row_q <= last_row_d;
      beat_q     <= beat_d;
    end
  end

  // The row swizzle travels with the read so the lane rotation lines up with returning data.
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe_q <= '0;
      for (int i = 0; i < RD_LAT; i++) s_pipe_q[i] <= '0;
    end else begin
      vld_pipe_q[0] <= issue;
      s_pipe_q[0]   <= s_issue;
      for (int i = 1; i < RD_LAT; i++) begin
        vld_pipe_q[i] <= vld_pipe_q[i-1];
        s_pipe_q[i]   <= s_pipe_q[i-1];
      end
    end
  end

  assign q_bank[0] = q0;
  assign q_bank[1] = q1;
  assign q_bank[2] = q2;
  assign q_bank[3] = q3;

  always_comb begin
    wr_data = '0;
    for (int k = 0; k < 4; k++) wr_data[12*k +: 12] = reduce(q_bank[2'(k) + s_pipe_q[RD_LAT-1]]);
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem_q[wr_ptr_q] <= wr_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (fire) rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, fire})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

endmodule

// File: tb/tb_ntt_poly_unloader.sv
// Bench for ntt_poly_unloader: bank memory model plus a natural-order coefficient reference.
module tb_ntt_poly_unloader;
  localparam int QM = 3329;

  logic        clk = 1'b0;
  logic        rst, start, tready;
  logic        busy, done, ren, tvalid, tlast;
  logic [6:0]  row;
  logic [11:0] q0, q1, q2, q3;
  logic [47:0] tdata;
  logic [1:0]  dbg_state;

  int checks = 0;
  int errors = 0;

  logic [11:0] coef [512];
  logic [11:0] bank_mem [4][128];
  logic [47:0] beat0_obs, beat1_obs;

  always #5 clk = ~clk;

  ntt_poly_unloader dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .ren(ren), .row(row), .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .tdata(tdata), .tvalid(tvalid), .tready(tready), .tlast(tlast),
    .dbg_state(dbg_state)
  );

  // Banks with one cycle of read latency.
  always @(posedge clk) begin
    if (ren) begin
      q0 <= bank_mem[0][row];
      q1 <= bank_mem[1][row];
      q2 <= bank_mem[2][row];
      q3 <= bank_mem[3][row];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int bank_of(input int a);
    return ((a & 3) + ((a >> 2) & 3) + ((a >> 4) & 3) + ((a >> 6) & 3) + ((a >> 8) & 1)) % 4;
  endfunction

  function automatic logic [11:0] ref_lane(input logic [11:0] x);
`ifdef UNLOAD_MODQ_EN
    if (int'(x) >= QM) return 12'(int'(x) - QM);
`endif
    return x;
  endfunction

  task automatic load_mem();
    for (int a = 0; a < 512; a++) bank_mem[bank_of(a)][a >> 2] = coef[a];
  endtask

  // mode: 0 tready high, 1 stall 20 cycles at first tvalid, 2 toggling, 3 random.
  task automatic unload(input int mode, input int rst_after, input bit poke_start);
    logic [47:0] exp_q[$];
    int cyc, beat, issued, first_valid, last_fire_cyc;
    bit prev_last_fire, lf, finished;
    for (int n = 0; n < 128; n++)
      exp_q.push_back({ref_lane(coef[4*n+3]), ref_lane(coef[4*n+2]),
                       ref_lane(coef[4*n+1]), ref_lane(coef[4*n])});
    beat = 0; issued = 0; first_valid = -1; last_fire_cyc = -1;
    prev_last_fire = 1'b0; finished = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    chk("start_busy", 64'(busy), 64'(1));
    chk("start_ren_row0", 64'({ren, row}), 64'({1'b1, 7'd0}));
    while (!finished && cyc < 3000) begin
      if (rst_after >= 0 && beat == rst_after + 1) begin
        rst = 1'b1;
        tready = 1'b0;
        @(negedge clk);
        chk("rst_outputs", 64'({busy, done, ren, row, tdata, tvalid, tlast}), 64'(0));
        rst = 1'b0;
        return;
      end
      if (tvalid && first_valid < 0) first_valid = cyc;
      case (mode)
        0:       tready = 1'b1;
        1:       tready = (first_valid >= 0) && (cyc >= first_valid + 20);
        2:       tready = (cyc % 2 == 1);
        default: tready = 1'($urandom_range(0, 1));
      endcase
      start = poke_start && (cyc == 10);
      chk("done", 64'(done), 64'(prev_last_fire));
      chk("busy", 64'(busy), 64'(!prev_last_fire));
      if (prev_last_fire) begin
        chk("done_cycle", 64'(cyc), 64'(last_fire_cyc + 1));
        finished = 1'b1;
      end
      if (ren) begin
        chk("ren_credit", 64'((issued - beat) < 4), 64'(1));
        chk("ren_row", 64'(row), 64'(issued));
        issued++;
      end
      if (mode == 1 && first_valid >= 0 && cyc == first_valid + 19) begin
        chk("stall_ren_cnt", 64'(issued), 64'(4));
        chk("stall_ren_low", 64'(ren), 64'(0));
      end
      lf = 1'b0;
      if (tvalid) begin
        if (beat == 0 && cyc == first_valid) chk("first_valid_lat", 64'(cyc), 64'(3));
        if (exp_q.size() == 0) chk("extra_beat", 64'(1), 64'(0));
        else chk("tdata", 64'(tdata), 64'(exp_q[0]));
        chk("tlast", 64'(tlast), 64'(beat == 127));
        if (tready) begin
          if (beat == 0) beat0_obs = tdata;
          if (beat == 1) beat1_obs = tdata;
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          if (beat == 127) begin
            lf = 1'b1;
            last_fire_cyc = cyc;
          end
          beat++;
        end
      end
      prev_last_fire = lf;
      @(negedge clk);
      cyc++;
    end
    start = 1'b0;
    if (!finished) chk("timeout", 64'(0), 64'(1));
    chk("beat_count", 64'(beat), 64'(128));
    chk("issue_count", 64'(issued), 64'(128));
    if (mode == 0) chk("throughput", 64'(last_fire_cyc), 64'(first_valid + 127));
    chk("idle_after_done", 64'({busy, done}), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0;
    tready = 1'b0;
    for (int a = 0; a < 512; a++) coef[a] = 12'(a);
    load_mem();
    repeat (3) @(negedge clk);
    chk("reset_outputs", 64'({busy, done, ren, row, tdata, tvalid, tlast}), 64'(0));
    rst = 1'b0;
    @(negedge clk);

    unload(0, -1, 1'b0);
    chk("identity_beat0", 64'(beat0_obs), 64'({12'd3, 12'd2, 12'd1, 12'd0}));
    unload(1, -1, 1'b0);
    unload(2, -1, 1'b0);

    unload(0, 50, 1'b0);
    repeat (5) begin
      @(negedge clk);
      chk("no_done_after_rst", 64'({busy, done}), 64'(0));
    end
    unload(0, -1, 1'b0);
    chk("restart_beat0", 64'(beat0_obs), 64'({12'd3, 12'd2, 12'd1, 12'd0}));

    unload(0, -1, 1'b1);

    coef[5] = 12'd3400;
    load_mem();
    unload(0, -1, 1'b0);
`ifdef UNLOAD_MODQ_EN
    chk("modq_lane1_beat1", 64'(beat1_obs[23:12]), 64'(71));
`else
    chk("modq_lane1_beat1", 64'(beat1_obs[23:12]), 64'(3400));
`endif

    repeat (3) begin
      for (int a = 0; a < 512; a++) coef[a] = 12'($urandom_range(0, 4095));
      load_mem();
      unload(3, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/ntt_poly_unloader.md
# ntt_poly_unloader

Read-side streaming port for the 4-bank coefficient memory of the 512-point NTT stage. After the stage FSM completes, this block reads the banks row by row through the conflict-free memory map and emits coefficients in natural order as a 48-bit valid/ready stream, four coefficients per beat. It sits between the data banks (shared read port, muxed in by the top level while the core is idle) and the host/DMA egress.

## Interface
- `RD_LAT`, 1: bank read latency in cycles, from `ren` to valid `q0..q3`.
- `FIFO_DEPTH`, 4: output buffer depth in beats; must be ≥ `RD_LAT`+1; full throughput needs ≥ `RD_LAT`+2.
- `Q_MOD`, 3329: modulus used by the optional final reduction.
- `clk`, input, 1: sole clock, rising edge.
- `rst`, input, 1: synchronous, active-high reset.
- `start`, input, 1: begin an unload; sampled only in IDLE.
- `busy`, output, 1: high from the cycle after an accepted `start` until `done`.
- `done`, output, 1: one-cycle pulse when the last beat has been accepted.
- `ren`, output, 1: bank read enable, common to all 4 banks.
- `row`, output, 7: bank row address, common to all 4 banks.
- `q0`..`q3`, input, 12 each: bank read data.
- `tdata`, output, 48: lane k sits in `tdata[12k+11:12k]` and carries coefficient 4n+k.
- `tvalid`, output, 1: beat available.
- `tready`, input, 1: sink accepts the beat.
- `tlast`, output, 1: high with beat 127.

## Operation
- **Memory map.** Logical address a[8:0] maps to row = a[8:2] and bank = (a[1:0] + a[3:2] + a[5:4] + a[7:6] + a[8]) mod 4. The four addresses of row n therefore occupy four distinct banks.
- **Lane swizzle.** With s = (r[6] + r[5:4] + r[3:2] + r[1:0]) mod 4, where r is the row, lane k = q[(k + s) mod 4]. s is computed at issue and carried alongside the read through the latency pipe.
- **FSM states:**
  - IDLE: `start` → RUN. Clears the row counter and the beat counter.
  - RUN: issues reads for rows 0..127. After row 127 is issued → DRAIN.
  - DRAIN: waits for the beat-127 handshake → DONE.
  - DONE: asserts `done` for one cycle → IDLE.
- **Credit rule.** outstanding = reads in flight + FIFO occupancy. `ren` is asserted only if outstanding < `FIFO_DEPTH`, so the FIFO never overflows.
- **Simultaneous events.** A FIFO write and a FIFO read in the same cycle are both legal, including when the FIFO is full (read frees the slot).
- **Stream rules.**
  - A beat transfers when `tvalid` and `tready` are both high.
  - While `tvalid` is high and `tready` is low, `tdata`, `tvalid` and `tlast` hold stable.
  - `tvalid` never depends combinationally on `tready`.
- **Ignored start.** `start` is ignored in RUN, DRAIN and DONE.
- **Data width.** Data is 12-bit and passed unmodified unless the configuration macro is defined.

## Timing
- **Reset values.** All outputs are 0: `busy`, `done`, `ren`, `row`, `tdata`, `tvalid`, `tlast`.
- **Effect of reset.** `rst` in any state flushes the FIFO and the in-flight pipe and forces IDLE on the next cycle. An in-progress unload is abandoned with no `done`.
- **Start timing.** `start` sampled at edge T: `busy` and `ren` (row 0) are high in cycle T+1.
- **First beat.** Data written to the FIFO at edge T+1+`RD_LAT`; `tvalid` high from cycle T+2+`RD_LAT` (T+3 at default).
- **Throughput.** With `tready` held high, one beat per cycle and rows issue back to back. 128 beats take 128 cycles after the first `tvalid`.
- **Completion.** `done` and the `busy` drop occur in the cycle after the beat-127 handshake. `start` can be accepted again in the cycle after `done`.
- **Row after last issue.** `row` holds its last issued value when `ren` is low.

## Configuration
- **`UNLOAD_MODQ_EN` defined:** each lane is replaced by x − `Q_MOD` if x ≥ `Q_MOD`, otherwise x. The reduction is applied in the FIFO-write path and adds no latency.
- **`UNLOAD_MODQ_EN` undefined:** lanes pass unchanged. No comparator logic is instantiated.

## Test plan
- **Full unload.** Preload coefficient i = i at its mapped bank/row. Pulse `start` with `tready`=1. Expect:
  - beat n lanes = {4n+3, 4n+2, 4n+1, 4n};
  - first `tvalid` 3 cycles after `start`;
  - `tlast` only on beat 127;
  - `done` pulse 1 cycle after beat 127.
- **Stall.** Hold `tready`=0 for 20 cycles after first `tvalid`. Expect:
  - exactly 4 `ren` cycles, then `ren` low;
  - `tdata`=beat 0 stable;
  - on release, beats 0..127 in order with no gaps or duplicates.
- **Toggling backpressure.** Drive `tready` 1010… for the whole transfer. Expect all 128 beats in order, with outstanding never exceeding 4.
- **Reset mid-run.** Assert `rst` after beat 50 is accepted. Expect all outputs 0 next cycle and no `done`. A new `start` yields beat 0 = {3, 2, 1, 0}.
- **Start while busy.** Pulse `start` during RUN. Expect no effect: exactly 128 beats and a single `done`.
- **MODQ reduction.** Preload coefficient 5 = 3400, then unload. Expect lane 1 of beat 1 = 71 with `UNLOAD_MODQ_EN` defined and 3400 without it.
